// File: rtl/trigger2.sv
// Gated set/reset trigger: per-bit bistable with edge-triggered, gate-qualified
// AC set/reset and level-sensitive active-low DC set/reset overrides.
module trigger2 #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_set_gate,
    input  logic [WIDTH-1:0] i_ac_set,
    input  logic [WIDTH-1:0] i_dc_set,
    input  logic [WIDTH-1:0] i_reset_gate,
    input  logic [WIDTH-1:0] i_ac_reset,
    input  logic [WIDTH-1:0] i_dc_reset,
    output logic [WIDTH-1:0] o_out,
    output logic [WIDTH-1:0] o_nout
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] ps_r;
    logic [WIDTH-1:0] pr_r;
    logic [WIDTH-1:0] set_edge_s;
    logic [WIDTH-1:0] reset_edge_s;
    logic [WIDTH-1:0] q_next_s;

    // Rising-edge detection; the gate must be high in the same cycle as the edge.
    always_comb begin
        set_edge_s   = i_ac_set & ~ps_r & i_set_gate;
        reset_edge_s = i_ac_reset & ~pr_r & i_reset_gate;
    end

    // Per-bit next state: DC reset, DC set, simultaneous AC toggle, AC set, AC reset, hold.
    always_comb begin
        q_next_s = q_r;
        for (int i = 0; i < WIDTH; i++) begin
            if (!i_dc_reset[i]) begin
                q_next_s[i] = 1'b0;
            end else if (!i_dc_set[i]) begin
                q_next_s[i] = 1'b1;
            end else if (set_edge_s[i] && reset_edge_s[i]) begin
                q_next_s[i] = ~q_r[i];
            end else if (set_edge_s[i]) begin
                q_next_s[i] = 1'b1;
            end else if (reset_edge_s[i]) begin
                q_next_s[i] = 1'b0;
            end else begin
                q_next_s[i] = q_r[i];
            end
        end
    end

    // State and edge history; history loads current inputs in reset so held-high levels are not edges.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            q_r  <= '0;
            ps_r <= i_ac_set;
            pr_r <= i_ac_reset;
        end else begin
            q_r  <= q_next_s;
            ps_r <= i_ac_set;
            pr_r <= i_ac_reset;
        end
    end

    assign o_out  = q_r;
    assign o_nout = ~q_r;

endmodule

// File: tb/tb_trigger2.sv
// Self-checking bench for trigger2 (WIDTH=4): directed test-plan steps followed
// by randomized stimulus, all compared against a per-bit behavioural model.
module tb_trigger2;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] set_gate, ac_set, dc_set, reset_gate, ac_reset, dc_reset;
    logic [W-1:0] out, nout;

    int tests = 0;
    int fails = 0;

    // Model state: stored bit and previous AC levels, one entry per bit.
    bit m_q [W];
    bit m_ps[W];
    bit m_pr[W];

    trigger2 #(.WIDTH(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_set_gate  (set_gate),
        .i_ac_set    (ac_set),
        .i_dc_set    (dc_set),
        .i_reset_gate(reset_gate),
        .i_ac_reset  (ac_reset),
        .i_dc_reset  (dc_reset),
        .o_out       (out),
        .o_nout      (nout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_vec();
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = m_q[i];
        return v;
    endfunction

    // Advance the model by one clock using the currently applied inputs.
    task automatic model_step();
        for (int i = 0; i < W; i++) begin
            bit rise_s, rise_r;
            rise_s = ac_set[i] && !m_ps[i] && set_gate[i];
            rise_r = ac_reset[i] && !m_pr[i] && reset_gate[i];
            if (!rst_n)            m_q[i] = 1'b0;
            else if (!dc_reset[i]) m_q[i] = 1'b0;
            else if (!dc_set[i])   m_q[i] = 1'b1;
            else if (rise_s && rise_r) m_q[i] = !m_q[i];
            else if (rise_s)       m_q[i] = 1'b1;
            else if (rise_r)       m_q[i] = 1'b0;
            m_ps[i] = ac_set[i];
            m_pr[i] = ac_reset[i];
        end
    endtask

    task automatic drive(input logic r, input logic [W-1:0] sg, input logic [W-1:0] as,
                         input logic [W-1:0] ds, input logic [W-1:0] rg,
                         input logic [W-1:0] ar, input logic [W-1:0] dr);
        rst_n = r; set_gate = sg; ac_set = as; dc_set = ds;
        reset_gate = rg; ac_reset = ar; dc_reset = dr;
    endtask

    // One clock: model update at the edge, then compare both outputs #1 later.
    task automatic tick(input string tag);
        logic [W-1:0] exp_v;
        @(posedge clk);
        model_step();
        #1;
        exp_v = model_vec();
        tests++;
        assert (out === exp_v) else begin
            fails++;
            $error("FAIL %s out: got %b expected %b", tag, out, exp_v);
        end
        tests++;
        assert (nout === ~exp_v) else begin
            fails++;
            $error("FAIL %s nout: got %b expected %b", tag, nout, ~exp_v);
        end
    endtask

    initial begin
        drive(1'b0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF);
        @(negedge clk);
        tick("reset1");
        tick("reset2");
        // Release with AC set already high and gate high: not an edge.
        rst_n = 1'b1;
        tick("release_held_high");
        // Gated AC set.
        drive(1'b1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'hF); tick("ac_set_low");
        ac_set = 4'hF;                                   tick("ac_set_rise");
        tests++;
        assert (out === 4'hF) else begin
            fails++;
            $error("FAIL ac_set_const: got %b expected %b", out, 4'hF);
        end
        ac_set = 4'h0; set_gate = 4'h0;                  tick("set_hold");
        // Gated AC reset, then blocked by a low gate.
        reset_gate = 4'hF;                               tick("rg_up");
        ac_reset = 4'hF;                                 tick("ac_reset_rise");
        ac_reset = 4'h0; dc_set = 4'h0;                  tick("dc_set");
        dc_set = 4'hF;                                   tick("dc_set_release");
        reset_gate = 4'h0; ac_reset = 4'hF;              tick("ac_reset_gated_off");
        reset_gate = 4'hF;                               tick("gate_late_no_edge");
        ac_reset = 4'h0;                                 tick("ac_reset_fall");
        // DC overrides, DC reset dominating, AC edge ignored under DC.
        dc_set = 4'h0;                                   tick("dc_set2");
        dc_reset = 4'h0;                                 tick("dc_both");
        dc_set = 4'hF; set_gate = 4'hF; ac_set = 4'hF;   tick("ac_under_dc_reset");
        dc_reset = 4'hF;                                 tick("dc_release_no_pending");
        ac_set = 4'h0;                                   tick("ac_set_fall");
        // Simultaneous AC edges toggle.
        ac_set = 4'hF; ac_reset = 4'hF;                  tick("toggle_up");
        ac_set = 4'h0; ac_reset = 4'h0;                  tick("both_fall");
        ac_set = 4'hF; ac_reset = 4'hF;                  tick("toggle_down");
        // Per-bit independence: 0001 -> 0100.
        drive(1'b1, 4'h0, 4'h0, 4'b1110, 4'h0, 4'h0, 4'hF); tick("bit0_dc_set");
        drive(1'b1, 4'b0100, 4'b0100, 4'hF, 4'h0, 4'h0, 4'b1110); tick("bit2_set_bit0_reset");
        tests++;
        assert (out === 4'b0100 && nout === 4'b1011) else begin
            fails++;
            $error("FAIL bitwise_const: got %b/%b expected 0100/1011", out, nout);
        end
        // Randomized stimulus; DC inputs mostly inactive, reset rare.
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 39) != 0),
                  W'($urandom), W'($urandom),
                  ~W'($urandom & $urandom & $urandom),
                  W'($urandom), W'($urandom),
                  ~W'($urandom & $urandom & $urandom));
            tick("random");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trigger2.md
Name: trigger2

Overview:
- Clocked model of a gated set/reset trigger (bistable latch with AC and DC inputs).
- Each bit has:
  - an edge-triggered, gate-qualified set path (AC set)
  - an edge-triggered, gate-qualified reset path (AC reset)
  - level-sensitive, active-low DC set and DC reset overrides
- Produces true and complement outputs. Used as a storage/control element in the emulated logic.

Parameters:
- WIDTH, 1, number of independent trigger bits. All data ports are WIDTH wide and are processed bitwise.

Ports:
- i_clk  input  1  system clock; all state updates on rising edge.
- i_rst_n  input  1  synchronous active-low reset.
- i_set_gate  input  WIDTH  conditions the AC set input; active high.
- i_ac_set  input  WIDTH  AC set; acts on 0->1 transition.
- i_dc_set  input  WIDTH  DC set; active low, level sensitive.
- i_reset_gate  input  WIDTH  conditions the AC reset input; active high.
- i_ac_reset  input  WIDTH  AC reset; acts on 0->1 transition.
- i_dc_reset  input  WIDTH  DC reset; active low, level sensitive.
- o_out  output  WIDTH  trigger state (registered).
- o_nout  output  WIDTH  complement of o_out, always exactly ~o_out.

Behaviour:
- Reset: one clock; reset is synchronous and active-low.
  - On a rising edge with i_rst_n=0: state q <= 0, so o_out=0 and o_nout=all ones.
  - Edge-history registers load the current i_ac_set/i_ac_reset values, so inputs already high at reset release are not treated as edges.
  - Reset has highest priority.
- Edge detection, per bit:
  - Registers ps and pr hold the previous-cycle i_ac_set and i_ac_reset.
  - set_edge = i_ac_set & ~ps & i_set_gate, with gate sampled in the same cycle as the edge.
  - reset_edge = i_ac_reset & ~pr & i_reset_gate.
  - ps/pr update every non-reset cycle.
  - A gate that is low when the edge is sampled blocks it. The edge is not remembered for a later gate rise.
  - Falling edges and held-high levels have no effect.
- Next state per bit, priority order (non-reset cycle):
  1. i_dc_reset=0 -> q<=0. DC reset dominates DC set when both are low.
  2. i_dc_set=0 -> q<=1.
  3. set_edge & reset_edge -> q<=~q (toggle).
  4. set_edge -> q<=1.
  5. reset_edge -> q<=0.
  6. Otherwise hold.
- While either DC input is low, AC edges are ignored. The edge history still updates, so no pending edge fires on DC release.
- Latency: o_out changes on the same rising edge at which the qualifying input level is first sampled. It is visible one clock after the input change.
- o_out and o_nout are both driven from the single state register. They are never equal.

Test Plan:
- Reset: hold i_rst_n=0 two clocks with all DC inputs =1 -> o_out=0, o_nout=1. Release reset with i_ac_set already 1 and gate 1 -> o_out stays 0.
- Gated AC set:
  - i_set_gate=1, then i_ac_set 0->1 -> o_out=1, o_nout=0 after the next edge.
  - Drop i_ac_set and i_set_gate -> o_out holds 1.
- Gated AC reset:
  - With o_out=1, i_reset_gate=1, then i_ac_reset 0->1 -> o_out=0.
  - Repeat with i_reset_gate=0 -> o_out stays 1.
- DC overrides:
  - i_dc_set=0 -> o_out=1 next clock.
  - Then i_dc_reset=0 with i_dc_set still 0 -> o_out=0.
  - Pulse AC set with gate high while i_dc_reset=0 -> o_out stays 0.
- Simultaneous AC edges, both gates high: from o_out=0 -> 1; second simultaneous pair -> 0.
- WIDTH=4: set bit 2 via AC, reset bit 0 via DC -> only the addressed bits change, e.g. o_out goes 4'b0001 -> 4'b0100, o_nout=4'b1011.
